// File: rtl/pipe_stage_chain_pkg.sv
// Shared defaults for the generic pipeline stage chain.
// The chain carries opaque payload bits, so only sizing constants live here.
package pipe_stage_chain_pkg;

  localparam int PSC_DEFAULT_WIDTH = 32;
  localparam int PSC_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/pipe_stage_chain_stage.sv
// One pipeline stage: a valid flag plus a payload register.
// Priority of next-state sources: flush, hold, bubble, load.
// An invalid entry always carries zero data, so bubbles are clean.
module pipe_stage
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH = PSC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             bubble,
  input  logic             flush,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid_next,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] data_next;

  // Select what this stage holds after the edge; flush beats hold.
  always_comb begin
    valid_next = 1'b0;
    data_next  = '0;
    if (flush) begin
      valid_next = 1'b0;
      data_next  = '0;
    end else if (hold) begin
      valid_next = valid;
      data_next  = data;
    end else if (bubble) begin
      valid_next = 1'b0;
      data_next  = '0;
    end else if (load_valid) begin
      valid_next = 1'b1;
      data_next  = load_data;
    end
  end

  // Stage register; reset discards any entry including held ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= valid_next;
      data  <= data_next;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Payload-agnostic chain of DEPTH pipeline stages with per-stage stall and
// flush. A stall freezes its stage and everything upstream; the stage just
// downstream of a frozen stage receives a bubble. The last stage has no
// downstream handshake, so its entry is dropped whenever it advances.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter  int WIDTH = PSC_DEFAULT_WIDTH,
  parameter  int DEPTH = PSC_DEFAULT_DEPTH,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [OCC_W-1:0]       occupancy
);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] valid_next;
  logic [OCC_W-1:0] occ_next;

  // hold[i] is the OR of stall[i..DEPTH-1]; flush deliberately plays no part.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc     = acc | stall[i];
      hold[i] = acc;
    end
  end

  assign in_ready = ~hold[0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic             up_bubble;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid  = in_valid;
      assign up_data   = in_data;
      assign up_bubble = 1'b0;
    end else begin : g_body
      assign up_valid  = stage_valid[i-1];
      assign up_data   = stage_data[(i-1)*WIDTH +: WIDTH];
      assign up_bubble = hold[i-1];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold[i]),
      .bubble    (up_bubble),
      .flush     (flush[i]),
      .load_valid(up_valid),
      .load_data (up_data),
      .valid_next(valid_next[i]),
      .valid     (stage_valid[i]),
      .data      (stage_data[i*WIDTH +: WIDTH])
    );
  end

  // Count the valid flags the stages will hold after this edge.
  always_comb begin
    occ_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_next = occ_next + OCC_W'(valid_next[k]);
    end
  end

  // Occupancy register tracks stage_valid exactly, cleared with the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios on a 4x32 chain and a
// randomised run on a 2-stage chain sized for the control word.
module tb_pipe_stage_chain;

  // Width of the rv32i control word carried by the control-word chain.
  localparam int CW = 37;

  typedef struct packed {
    logic [3:0]   v;
    logic [127:0] d;
    logic [2:0]   occ;
  } exp_a_t;

  typedef struct {
    logic        rst;
    logic [3:0]  st;
    logic [3:0]  fl;
    logic        vin;
    logic [31:0] din;
    logic        rdy;
    exp_a_t      e;
  } step_a_t;

  typedef struct packed {
    logic [1:0]      v;
    logic [2*CW-1:0] d;
    logic [1:0]      occ;
  } exp_b_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic          a_in_valid;
  logic [31:0]   a_in_data;
  logic          a_in_ready;
  logic [3:0]    a_stall;
  logic [3:0]    a_flush;
  logic [127:0]  a_stage_data;
  logic [3:0]    a_stage_valid;
  logic [2:0]    a_occupancy;

  logic          b_in_valid;
  logic [CW-1:0] b_in_data;
  logic          b_in_ready;
  logic [1:0]    b_stall;
  logic [1:0]    b_flush;
  logic [2*CW-1:0] b_stage_data;
  logic [1:0]    b_stage_valid;
  logic [1:0]    b_occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  exp_a_t qa[$];
  exp_b_t qb[$];

  pipe_stage_chain #(.WIDTH(32), .DEPTH(4)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (a_in_valid),
    .in_data    (a_in_data),
    .in_ready   (a_in_ready),
    .stall      (a_stall),
    .flush      (a_flush),
    .stage_data (a_stage_data),
    .stage_valid(a_stage_valid),
    .occupancy  (a_occupancy)
  );

  pipe_stage_chain #(.WIDTH(CW), .DEPTH(2)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (b_in_valid),
    .in_data    (b_in_data),
    .in_ready   (b_in_ready),
    .stall      (b_stall),
    .flush      (b_flush),
    .stage_data (b_stage_data),
    .stage_valid(b_stage_valid),
    .occupancy  (b_occupancy)
  );

  function automatic exp_a_t mk_a(logic [31:0] s3, logic [31:0] s2, logic [31:0] s1,
                                  logic [31:0] s0, logic [3:0] v, int occ);
    exp_a_t e;
    e.d   = {s3, s2, s1, s0};
    e.v   = v;
    e.occ = 3'(occ);
    return e;
  endfunction

  function automatic step_a_t stp(logic rst, logic [3:0] st, logic [3:0] fl, logic vin,
                                  logic [31:0] din, logic rdy, exp_a_t e);
    step_a_t s;
    s.rst = rst; s.st = st; s.fl = fl; s.vin = vin; s.din = din; s.rdy = rdy; s.e = e;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then push 0x11..0x44 so stage 3..0 hold 0x11, 0x22, 0x33, 0x44.
  task automatic load_full();
    reset = 1'b1; a_stall = '0; a_flush = '0; a_in_valid = 1'b0; a_in_data = '0;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'(k * 'h11);
      tick();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    step_a_t steps[$];
    exp_a_t  e;
    steps.push_back(stp(1, 4'b0001, 4'b0000, 1, 32'hdead, 0, mk_a(0, 0, 0, 0, 4'b0000, 0)));
    steps.push_back(stp(1, 4'b0000, 4'b1111, 1, 32'hbeef, 1, mk_a(0, 0, 0, 0, 4'b0000, 0)));
    for (int k = 0; k < steps.size(); k++) begin
      reset = steps[k].rst; a_stall = steps[k].st; a_flush = steps[k].fl;
      a_in_valid = steps[k].vin; a_in_data = steps[k].din;
      qa.push_back(steps[k].e);
      #1;
      n_checks++;
      if (a_in_ready !== steps[k].rdy) $display("FAIL reset in_ready step %0d: got %b want %b", k, a_in_ready, steps[k].rdy);
      else n_pass++;
      tick();
      e = qa.pop_front();
      n_checks++;
      if (a_stage_data !== e.d) $display("FAIL reset data step %0d: got %h want %h", k, a_stage_data, e.d);
      else n_pass++;
      n_checks++;
      if (a_stage_valid !== e.v) $display("FAIL reset valid step %0d: got %b want %b", k, a_stage_valid, e.v);
      else n_pass++;
      n_checks++;
      if (a_occupancy !== e.occ) $display("FAIL reset occupancy step %0d: got %0d want %0d", k, a_occupancy, e.occ);
      else n_pass++;
    end
  endtask

  task automatic test_free_flow();
    step_a_t steps[$];
    exp_a_t  e;
    steps.push_back(stp(0, 0, 0, 1, 32'h11, 1, mk_a(0, 0, 0, 'h11, 4'b0001, 1)));
    steps.push_back(stp(0, 0, 0, 1, 32'h22, 1, mk_a(0, 0, 'h11, 'h22, 4'b0011, 2)));
    steps.push_back(stp(0, 0, 0, 1, 32'h33, 1, mk_a(0, 'h11, 'h22, 'h33, 4'b0111, 3)));
    steps.push_back(stp(0, 0, 0, 1, 32'h44, 1, mk_a('h11, 'h22, 'h33, 'h44, 4'b1111, 4)));
    // 0x11 falls off the end; an idle input enters stage 0 as a bubble.
    steps.push_back(stp(0, 0, 0, 0, 32'h5a, 1, mk_a('h22, 'h33, 'h44, 0, 4'b1110, 3)));
    for (int k = 0; k < steps.size(); k++) begin
      reset = steps[k].rst; a_stall = steps[k].st; a_flush = steps[k].fl;
      a_in_valid = steps[k].vin; a_in_data = steps[k].din;
      qa.push_back(steps[k].e);
      #1;
      n_checks++;
      if (a_in_ready !== steps[k].rdy) $display("FAIL free_flow in_ready step %0d: got %b want %b", k, a_in_ready, steps[k].rdy);
      else n_pass++;
      tick();
      e = qa.pop_front();
      n_checks++;
      if (a_stage_data !== e.d) $display("FAIL free_flow data step %0d: got %h want %h", k, a_stage_data, e.d);
      else n_pass++;
      n_checks++;
      if (a_stage_valid !== e.v) $display("FAIL free_flow valid step %0d: got %b want %b", k, a_stage_valid, e.v);
      else n_pass++;
      n_checks++;
      if (a_occupancy !== e.occ) $display("FAIL free_flow occupancy step %0d: got %0d want %0d", k, a_occupancy, e.occ);
      else n_pass++;
    end
  endtask

  task automatic test_middle_stall();
    step_a_t steps[$];
    exp_a_t  e;
    load_full();
    steps.push_back(stp(0, 4'b0100, 0, 1, 32'h66, 0, mk_a(0, 'h22, 'h33, 'h44, 4'b0111, 3)));
    steps.push_back(stp(0, 4'b0100, 0, 1, 32'h66, 0, mk_a(0, 'h22, 'h33, 'h44, 4'b0111, 3)));
    steps.push_back(stp(0, 4'b0000, 0, 1, 32'h66, 1, mk_a('h22, 'h33, 'h44, 'h66, 4'b1111, 4)));
    for (int k = 0; k < steps.size(); k++) begin
      reset = steps[k].rst; a_stall = steps[k].st; a_flush = steps[k].fl;
      a_in_valid = steps[k].vin; a_in_data = steps[k].din;
      qa.push_back(steps[k].e);
      #1;
      n_checks++;
      if (a_in_ready !== steps[k].rdy) $display("FAIL mid_stall in_ready step %0d: got %b want %b", k, a_in_ready, steps[k].rdy);
      else n_pass++;
      tick();
      e = qa.pop_front();
      n_checks++;
      if (a_stage_data !== e.d) $display("FAIL mid_stall data step %0d: got %h want %h", k, a_stage_data, e.d);
      else n_pass++;
      n_checks++;
      if (a_stage_valid !== e.v) $display("FAIL mid_stall valid step %0d: got %b want %b", k, a_stage_valid, e.v);
      else n_pass++;
      n_checks++;
      if (a_occupancy !== e.occ) $display("FAIL mid_stall occupancy step %0d: got %0d want %0d", k, a_occupancy, e.occ);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    step_a_t steps[$];
    exp_a_t  e;
    load_full();
    steps.push_back(stp(0, 0, 4'b0011, 1, 32'h55, 1, mk_a('h22, 'h33, 0, 0, 4'b1100, 2)));
    steps.push_back(stp(0, 0, 4'b0000, 0, 32'h00, 1, mk_a('h33, 0, 0, 0, 4'b1000, 1)));
    for (int k = 0; k < steps.size(); k++) begin
      reset = steps[k].rst; a_stall = steps[k].st; a_flush = steps[k].fl;
      a_in_valid = steps[k].vin; a_in_data = steps[k].din;
      qa.push_back(steps[k].e);
      #1;
      n_checks++;
      if (a_in_ready !== steps[k].rdy) $display("FAIL flush in_ready step %0d: got %b want %b", k, a_in_ready, steps[k].rdy);
      else n_pass++;
      tick();
      e = qa.pop_front();
      n_checks++;
      if (a_stage_data !== e.d) $display("FAIL flush data step %0d: got %h want %h", k, a_stage_data, e.d);
      else n_pass++;
      n_checks++;
      if (a_stage_valid !== e.v) $display("FAIL flush valid step %0d: got %b want %b", k, a_stage_valid, e.v);
      else n_pass++;
      n_checks++;
      if (a_occupancy !== e.occ) $display("FAIL flush occupancy step %0d: got %0d want %0d", k, a_occupancy, e.occ);
      else n_pass++;
    end
  endtask

  task automatic test_stall_flush();
    step_a_t steps[$];
    exp_a_t  e;
    load_full();
    steps.push_back(stp(0, 4'b0010, 4'b0010, 1, 32'h77, 0, mk_a('h22, 0, 0, 'h44, 4'b1001, 2)));
    steps.push_back(stp(0, 4'b0010, 4'b0000, 1, 32'h77, 0, mk_a(0, 0, 0, 'h44, 4'b0001, 1)));
    steps.push_back(stp(0, 4'b0000, 4'b0000, 1, 32'h88, 1, mk_a(0, 0, 'h44, 'h88, 4'b0011, 2)));
    for (int k = 0; k < steps.size(); k++) begin
      reset = steps[k].rst; a_stall = steps[k].st; a_flush = steps[k].fl;
      a_in_valid = steps[k].vin; a_in_data = steps[k].din;
      qa.push_back(steps[k].e);
      #1;
      n_checks++;
      if (a_in_ready !== steps[k].rdy) $display("FAIL stall_flush in_ready step %0d: got %b want %b", k, a_in_ready, steps[k].rdy);
      else n_pass++;
      tick();
      e = qa.pop_front();
      n_checks++;
      if (a_stage_data !== e.d) $display("FAIL stall_flush data step %0d: got %h want %h", k, a_stage_data, e.d);
      else n_pass++;
      n_checks++;
      if (a_stage_valid !== e.v) $display("FAIL stall_flush valid step %0d: got %b want %b", k, a_stage_valid, e.v);
      else n_pass++;
      n_checks++;
      if (a_occupancy !== e.occ) $display("FAIL stall_flush occupancy step %0d: got %0d want %0d", k, a_occupancy, e.occ);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stall();
    step_a_t steps[$];
    exp_a_t  e;
    load_full();
    steps.push_back(stp(1, 4'b1000, 0, 1, 32'h99, 0, mk_a(0, 0, 0, 0, 4'b0000, 0)));
    steps.push_back(stp(1, 4'b1000, 0, 1, 32'h99, 0, mk_a(0, 0, 0, 0, 4'b0000, 0)));
    steps.push_back(stp(0, 4'b0000, 0, 1, 32'hab, 1, mk_a(0, 0, 0, 'hab, 4'b0001, 1)));
    for (int k = 0; k < steps.size(); k++) begin
      reset = steps[k].rst; a_stall = steps[k].st; a_flush = steps[k].fl;
      a_in_valid = steps[k].vin; a_in_data = steps[k].din;
      qa.push_back(steps[k].e);
      #1;
      n_checks++;
      if (a_in_ready !== steps[k].rdy) $display("FAIL rst_stall in_ready step %0d: got %b want %b", k, a_in_ready, steps[k].rdy);
      else n_pass++;
      tick();
      e = qa.pop_front();
      n_checks++;
      if (a_stage_data !== e.d) $display("FAIL rst_stall data step %0d: got %h want %h", k, a_stage_data, e.d);
      else n_pass++;
      n_checks++;
      if (a_stage_valid !== e.v) $display("FAIL rst_stall valid step %0d: got %b want %b", k, a_stage_valid, e.v);
      else n_pass++;
      n_checks++;
      if (a_occupancy !== e.occ) $display("FAIL rst_stall occupancy step %0d: got %0d want %0d", k, a_occupancy, e.occ);
      else n_pass++;
    end
  endtask

  task automatic test_random_depth2();
    logic          mv0, mv1, nv0, nv1, h0, h1;
    logic [CW-1:0] md0, md1, nd0, nd1;
    exp_b_t        e;
    a_stall = '0; a_flush = '0; a_in_valid = 1'b0; a_in_data = '0;
    reset = 1'b1; b_stall = '0; b_flush = '0; b_in_valid = 1'b0; b_in_data = '0;
    tick();
    mv0 = 1'b0; mv1 = 1'b0; md0 = '0; md1 = '0;
    for (int c = 0; c < 1000; c++) begin
      reset      = ($urandom_range(0, 63) == 0);
      b_stall    = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      b_flush    = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      b_in_valid = ($urandom_range(0, 9) < 7);
      b_in_data  = CW'({$urandom(), $urandom()});
      h1 = b_stall[1];
      h0 = b_stall[0] | b_stall[1];
      nv0 = 1'b0; nd0 = '0; nv1 = 1'b0; nd1 = '0;
      if (!reset) begin
        if (!b_flush[1]) begin
          if (h1) begin nv1 = mv1; nd1 = md1; end
          else if (!h0) begin nv1 = mv0; nd1 = md0; end
        end
        if (!b_flush[0]) begin
          if (h0) begin nv0 = mv0; nd0 = md0; end
          else if (b_in_valid) begin nv0 = 1'b1; nd0 = b_in_data; end
        end
      end
      e.v = {nv1, nv0};
      e.d = {nd1, nd0};
      e.occ = 2'(nv0) + 2'(nv1);
      qb.push_back(e);
      #1;
      n_checks++;
      if (b_in_ready !== !h0) $display("FAIL rand in_ready cycle %0d: got %b want %b", c, b_in_ready, !h0);
      else n_pass++;
      tick();
      mv0 = nv0; mv1 = nv1; md0 = nd0; md1 = nd1;
      e = qb.pop_front();
      n_checks++;
      if (b_stage_data !== e.d) $display("FAIL rand data cycle %0d: got %h want %h", c, b_stage_data, e.d);
      else n_pass++;
      n_checks++;
      if (b_stage_valid !== e.v) $display("FAIL rand valid cycle %0d: got %b want %b", c, b_stage_valid, e.v);
      else n_pass++;
      n_checks++;
      if (b_occupancy !== e.occ) $display("FAIL rand occupancy cycle %0d: got %0d want %0d", c, b_occupancy, e.occ);
      else n_pass++;
      n_checks++;
      if (32'(b_occupancy) !== $countones(b_stage_valid))
        $display("FAIL rand occ_popcount cycle %0d: got %0d want %0d", c, b_occupancy, $countones(b_stage_valid));
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    b_in_valid = 1'b0; b_in_data = '0; b_stall = '0; b_flush = '0;
    reset = 1'b1; a_stall = '0; a_flush = '0; a_in_valid = 1'b0; a_in_data = '0;
    #2;
    test_reset();
    test_free_flow();
    test_middle_stall();
    test_flush();
    test_stall_flush();
    test_reset_mid_stall();
    test_random_depth2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
